// File: rtl/counter_seq_arbiter.sv
// Two-requester round-robin front end for a mod-N up/down counter.
// Serves each target by walking the short way round or by a direct load.
module counter_seq_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 14,
    parameter int MAX_STEPS = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_target,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_target,
    input  logic             req1_mode,
    input  logic [WIDTH-1:0] count,
    output logic             load,
    output logic             up_down,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err
);

    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam logic [WIDTH:0] MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] HALF = (WIDTH+1)'(MODULUS / 2);
    localparam logic [SW-1:0]  MAXS = SW'(MAX_STEPS);

    typedef enum logic [1:0] {IDLE, WALK, JUMP} state_t;

    state_t           r_state, w_next;
    logic             r_rr, r_id, r_dir;
    logic [WIDTH-1:0] r_target;
    logic [SW-1:0]    r_steps;
    logic             r_done, r_err, r_done_id;

    logic             w_gnt1, w_acc, w_mode, w_illegal, w_up;
    logic             w_step, w_fin_done, w_fin_err;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH:0]   w_tx, w_cx, w_diff;

    // Grant: lone requester wins, otherwise the rr pointer decides
    always_comb begin
        w_gnt1     = req1_valid & (~req0_valid | r_rr);
        w_acc      = (r_state == IDLE) & (req0_valid | req1_valid);
        w_tgt      = w_gnt1 ? req1_target : req0_target;
        w_mode     = w_gnt1 ? req1_mode : req0_mode;
        w_tx       = {1'b0, w_tgt};
        w_cx       = {1'b0, count};
        w_illegal  = (w_tx >= MOD);
        w_diff     = (w_tx >= w_cx) ? (w_tx - w_cx) : (w_tx + MOD - w_cx);
        w_up       = (w_diff <= HALF);
        req0_ready = reset & w_acc & ~w_gnt1;
        req1_ready = reset & w_acc & w_gnt1;
    end

    always_comb begin
        w_next     = r_state;
        load       = 1'b1;
        up_down    = 1'b1;
        data_in    = count;
        w_step     = 1'b0;
        w_fin_done = 1'b0;
        w_fin_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_acc && !w_illegal) begin
                    w_next = w_mode ? JUMP : WALK;
                end
            end
            WALK: begin
                if (count == r_target) begin
                    w_next     = IDLE;
                    w_fin_done = 1'b1;
                end else if (r_steps >= MAXS) begin
                    w_next    = IDLE;
                    w_fin_err = 1'b1;
                end else begin
                    load    = 1'b0;
                    up_down = r_dir;
                    data_in = '0;
                    w_step  = 1'b1;
                end
            end
            JUMP: begin
                data_in    = r_target;
                w_next     = IDLE;
                w_fin_done = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        // Counter must sit idle-safe while reset is held
        if (!reset) begin
            load    = 1'b0;
            up_down = 1'b1;
            data_in = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rr      <= 1'b0;
            r_id      <= 1'b0;
            r_dir     <= 1'b1;
            r_target  <= '0;
            r_steps   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fin_done;
            r_err   <= w_fin_err;
            if (w_step) begin
                r_steps <= r_steps + 1'b1;
            end
            if (w_acc) begin
                r_rr     <= ~w_gnt1;
                r_id     <= w_gnt1;
                r_target <= w_tgt;
                r_dir    <= w_up;
                r_steps  <= '0;
                if (w_illegal) begin
                    r_err     <= 1'b1;
                    r_done_id <= w_gnt1;
                end
            end
            if (w_fin_done || w_fin_err) begin
                r_done_id <= r_id;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign done_id = r_done_id;

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Directed bench for counter_seq_arbiter driving a behavioural mod-14 counter.
// ext_set lets the bench place or disturb the counter value directly.
module tb_counter_seq_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req0_ready, req0_mode = 1'b0;
    logic       req1_valid = 1'b0, req1_ready, req1_mode = 1'b0;
    logic [3:0] req0_target = '0, req1_target = '0;
    logic [3:0] count, data_in;
    logic       load, up_down, busy, done, done_id, err;
    logic       ext_set = 1'b1;
    logic [3:0] ext_val = 4'd6;
    int         n_chk = 0, n_pass = 0;

    counter_seq_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_target(req0_target), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_target(req1_target), .req1_mode(req1_mode),
        .count(count), .load(load), .up_down(up_down), .data_in(data_in),
        .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ext_set) count <= ext_val;
        else if (load) count <= data_in;
        else if (up_down) count <= (count == 4'd13) ? 4'd0 : count + 4'd1;
        else count <= (count == 4'd0) ? 4'd13 : count - 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic setcount(input logic [3:0] v);
        ext_val = v;
        ext_set = 1'b1;
        @(negedge clock);
        ext_set = 1'b0;
    endtask

    task automatic issue(input logic id, input logic [3:0] tgt, input logic mode);
        if (id) begin
            req1_valid = 1'b1; req1_target = tgt; req1_mode = mode;
        end else begin
            req0_valid = 1'b1; req0_target = tgt; req0_mode = mode;
        end
        #1;
        n_chk++;
        if ((id ? req1_ready : req0_ready) !== 1'b1)
            $display("FAIL issue_ready id=%0d got %b want 1", id, id ? req1_ready : req0_ready);
        else n_pass++;
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; ext_val = 4'd6; ext_set = 1'b1;
        req0_valid = 1'b1; req0_target = 4'd3;
        @(negedge clock); @(negedge clock);
        n_chk++; if (load !== 1'b0) $display("FAIL rst_load got %b want 0", load); else n_pass++;
        n_chk++; if (up_down !== 1'b1) $display("FAIL rst_updown got %b want 1", up_down); else n_pass++;
        n_chk++; if (data_in !== 4'd0) $display("FAIL rst_data got %0d want 0", data_in); else n_pass++;
        n_chk++; if (req0_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req0_ready); else n_pass++;
        n_chk++; if ({busy, done, done_id, err} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {busy, done, done_id, err}); else n_pass++;
        reset = 1'b1; ext_set = 1'b0; req0_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_chk++;
            if (load !== 1'b1 || data_in !== 4'd6 || count !== 4'd6)
                $display("FAIL idle_hold c=%0d got load=%b data=%0d cnt=%0d want 1/6/6", c, load, data_in, count);
            else n_pass++;
            n_chk++;
            if ({busy, req0_ready, req1_ready} !== 3'b0)
                $display("FAIL idle_flags c=%0d got %b want 000", c, {busy, req0_ready, req1_ready});
            else n_pass++;
        end
    endtask

    task automatic test_walk_up;
        setcount(4'd2);
        issue(1'b0, 4'd5, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            n_chk++;
            if (up_down !== 1'b1 || load !== 1'b0 || busy !== 1'b1 || count !== 4'(1 + c))
                $display("FAIL walkup c=%0d got ud=%b ld=%b busy=%b cnt=%0d want 1/0/1/%0d", c, up_down, load, busy, count, 1 + c);
            else n_pass++;
            @(negedge clock);
        end
        n_chk++;
        if (count !== 4'd5 || load !== 1'b1 || data_in !== 4'd5 || done !== 1'b0)
            $display("FAIL walkup_hold got cnt=%0d ld=%b data=%0d done=%b want 5/1/5/0", count, load, data_in, done);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (done !== 1'b1 || done_id !== 1'b0 || busy !== 1'b0)
            $display("FAIL walkup_done got done=%b id=%b busy=%b want 1/0/0", done, done_id, busy);
        else n_pass++;
    endtask

    task automatic test_walk_down;
        int exp_c[4] = '{1, 0, 13, 12};
        setcount(4'd1);
        issue(1'b1, 4'd12, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            n_chk++;
            if (up_down !== 1'b0 || load !== 1'b0 || count !== 4'(exp_c[c-1]))
                $display("FAIL walkdn c=%0d got ud=%b ld=%b cnt=%0d want 0/0/%0d", c, up_down, load, count, exp_c[c-1]);
            else n_pass++;
            @(negedge clock);
        end
        n_chk++;
        if (count !== 4'd12 || load !== 1'b1 || data_in !== 4'd12)
            $display("FAIL walkdn_hold got cnt=%0d ld=%b data=%0d want 12/1/12", count, load, data_in);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (done !== 1'b1 || done_id !== 1'b1)
            $display("FAIL walkdn_done got done=%b id=%b want 1/1", done, done_id);
        else n_pass++;
    endtask

    task automatic test_tie_and_jump;
        setcount(4'd0);
        issue(1'b0, 4'd7, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            n_chk++;
            if (up_down !== 1'b1 || load !== 1'b0)
                $display("FAIL tie_step c=%0d got ud=%b ld=%b want 1/0", c, up_down, load);
            else n_pass++;
            @(negedge clock);
        end
        n_chk++;
        if (count !== 4'd7 || done !== 1'b0 || load !== 1'b1)
            $display("FAIL tie_arrive got cnt=%0d done=%b ld=%b want 7/0/1", count, done, load);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (done !== 1'b1) $display("FAIL tie_done got %b want 1", done); else n_pass++;
        issue(1'b0, 4'd3, 1'b1);
        n_chk++;
        if (load !== 1'b1 || data_in !== 4'd3 || busy !== 1'b1)
            $display("FAIL jump_load got ld=%b data=%0d busy=%b want 1/3/1", load, data_in, busy);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (count !== 4'd3 || done !== 1'b1 || done_id !== 1'b0 || busy !== 1'b0)
            $display("FAIL jump_done got cnt=%0d done=%b id=%b busy=%b want 3/1/0/0", count, done, done_id, busy);
        else n_pass++;
    endtask

    task automatic pulse_reset;
        reset = 1'b0; ext_val = 4'd0; ext_set = 1'b1;
        @(negedge clock);
        reset = 1'b1; ext_set = 1'b0;
    endtask

    task automatic test_round_robin;
        logic exp_id[3] = '{1'b0, 1'b1, 1'b0};
        pulse_reset();
        req0_valid = 1'b1; req0_target = 4'd1; req0_mode = 1'b1;
        req1_valid = 1'b1; req1_target = 4'd2; req1_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_chk++;
            if (req0_ready !== (i % 4 == 0) || req1_ready !== (i % 4 == 2))
                $display("FAIL rr_grant i=%0d got r0=%b r1=%b want %b/%b", i, req0_ready, req1_ready, i % 4 == 0, i % 4 == 2);
            else n_pass++;
            if (i == 2 || i == 4 || i == 6) begin
                n_chk++;
                if (done !== 1'b1 || done_id !== exp_id[i/2-1] || count !== ((i % 4 == 2) ? 4'd1 : 4'd2))
                    $display("FAIL rr_done i=%0d got done=%b id=%b cnt=%0d want 1/%b/%0d", i, done, done_id, count, exp_id[i/2-1], (i % 4 == 2) ? 1 : 2);
                else n_pass++;
            end
            @(negedge clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock); @(negedge clock);
    endtask

    task automatic test_illegal;
        setcount(4'd4);
        issue(1'b1, 4'd15, 1'b0);
        n_chk++;
        if (err !== 1'b1 || done_id !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || count !== 4'd4)
            $display("FAIL ill1 got err=%b id=%b done=%b busy=%b cnt=%0d want 1/1/0/0/4", err, done_id, done, busy, count);
        else n_pass++;
        issue(1'b0, 4'd14, 1'b1);
        n_chk++;
        if (err !== 1'b1 || done_id !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || count !== 4'd4)
            $display("FAIL ill0 got err=%b id=%b done=%b busy=%b cnt=%0d want 1/0/0/0/4", err, done_id, done, busy, count);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (err !== 1'b0 || count !== 4'd4) $display("FAIL ill_clear got err=%b cnt=%0d want 0/4", err, count); else n_pass++;
    endtask

    task automatic test_reset_mid_walk;
        setcount(4'd5);
        issue(1'b1, 4'd2, 1'b0);
        @(negedge clock);
        reset = 1'b0; ext_val = count; ext_set = 1'b1;
        #1;
        n_chk++;
        if (load !== 1'b0 || up_down !== 1'b1 || data_in !== 4'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst got ld=%b ud=%b data=%0d busy=%b done=%b want 0/1/0/0/0", load, up_down, data_in, busy, done);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1; ext_set = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_chk++;
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || load !== 1'b1 || count !== 4'd4)
                $display("FAIL midrst_after c=%0d got done=%b err=%b busy=%b ld=%b cnt=%0d want 0/0/0/1/4", c, done, err, busy, load, count);
            else n_pass++;
        end
    endtask

    task automatic test_disturb;
        setcount(4'd0);
        issue(1'b1, 4'd5, 1'b0);
        @(negedge clock);
        ext_val = 4'd10; ext_set = 1'b1;
        @(negedge clock);
        ext_set = 1'b0;
        n_chk++;
        if (count !== 4'd10) $display("FAIL dist_push got cnt=%0d want 10", count); else n_pass++;
        for (int c = 4; c <= 8; c++) @(negedge clock);
        n_chk++;
        if (load !== 1'b1 || data_in !== 4'd1 || busy !== 1'b1 || count !== 4'd1 || err !== 1'b0)
            $display("FAIL dist_abort got ld=%b data=%0d busy=%b cnt=%0d err=%b want 1/1/1/1/0", load, data_in, busy, count, err);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (err !== 1'b1 || done !== 1'b0 || done_id !== 1'b1 || busy !== 1'b0 || count !== 4'd1)
            $display("FAIL dist_err got err=%b done=%b id=%b busy=%b cnt=%0d want 1/0/1/0/1", err, done, done_id, busy, count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_walk_up();
        test_walk_down();
        test_tie_and_jump();
        test_round_robin();
        test_illegal();
        test_reset_mid_walk();
        test_disturb();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_seq_arbiter.md
Name: counter_seq_arbiter

Overview:
- Shares the mod-14 up/down counter between two requesters. Each requester asks for a target value.
- Round-robin arbitration picks the next request to service.
- The block drives the counter's load, up_down and data_in to reach the target, either by walking the shortest path around the ring or by jumping (loading) directly.
- It holds the counter steady between commands by reloading the current count, and reports completion and errors.

Parameters:
- WIDTH, 4, width of count, data_in and targets.
- MODULUS, 14, counter modulus; legal values are 0..MODULUS-1.
- MAX_STEPS, 7, walk-step budget (MODULUS/2) before a walk is aborted.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_target  in  WIDTH  requester 0 target value.
- req0_mode  in  1  0 = walk, 1 = jump.
- req1_valid, req1_ready, req1_target, req1_mode: same as requester 0, for requester 1.
- count  in  WIDTH  current counter value (counter output).
- load  out  1  to counter load.
- up_down  out  1  to counter up_down; 1 = up.
- data_in  out  WIDTH  to counter data_in.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester id of the completed or errored command.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr pointer=0 (requester 0 favoured).
  - busy=0, done=0, done_id=0, err=0.
  - While reset is low: load=0, up_down=1, data_in=0, both readys=0.
- States: IDLE, WALK, JUMP.
- IDLE:
  - Drives load=1, data_in=count, up_down=1, so the counter holds.
  - readyX is combinational and equals validX AND grant.
  - Grant goes to the only valid requester. If both are valid, the rr pointer wins.
  - On acceptance:
    - rr pointer moves to the other requester.
    - Target, mode and id are latched.
    - busy=1 from the next cycle.
  - At most one accept per cycle. readys are 0 in WALK and JUMP.
- Illegal target (target >= MODULUS):
  - The command is accepted (handshake completes) and no operation is performed.
  - err=1 and done_id=id in the next cycle. The block stays in IDLE and busy stays 0.
  - done is not pulsed.
- Direction is computed at acceptance from the count sampled in that cycle:
  - d = (target - count) mod MODULUS.
  - up = (d <= MODULUS/2); the tie at d=7 goes up.
  - Steps = up ? d : MODULUS - d.
- WALK (mode=0):
  - While count != target: load=0, up_down=dir, and the step counter increments.
  - Cycle in which count == target: load=1, data_in=count (hold). Next state is IDLE, with done=1 and done_id registered.
  - If the step counter reaches MAX_STEPS with count != target (counter disturbed externally): drive a hold, go to IDLE, and pulse err=1 with done_id. done stays 0.
- JUMP (mode=1):
  - One cycle with load=1, data_in=target.
  - Next state is IDLE with done=1.
- Latency (cycle 0 = accept cycle):
  - Walk of n steps: count==target in cycle n+1; done in cycle n+2.
  - n=0: done in cycle 2.
  - Jump: count==target and done both in cycle 2.
- busy=1 from cycle 1 through the cycle before done.
- done, err and done_id are registered. done_id holds its value between pulses.
- Wrap-around is handled by the counter. The controller never drives data_in >= MODULUS, except data_in=count while holding.
- Reset asserted mid-command aborts it: no done or err pulse, and the latched command is discarded.
- A new request may be accepted in the cycle done is high, since the block is in IDLE then.

Test Plan:
- Reset, then idle 5 cycles with count=6 -> load=1, data_in=6 every cycle; count stays 6; busy=0, readys=0.
- count=2, req0 walk target 5 accepted cycle 0 -> up_down=1 in cycles 1-3; count=5 in cycle 4 with load hold; done=1, done_id=0 in cycle 5.
- count=1, req1 walk target 12 -> direction down; count sequence 0, 13, 12 (3 steps); done=1, done_id=1 in cycle 5.
- count=0, walk target 7 -> tie, goes up 7 steps; done in cycle 9. Then a jump to 3 -> load=1, data_in=3 in cycle 1; done in cycle 2.
- Both requesters valid continuously, each issuing jumps -> grants alternate 0, 1, 0, 1 starting with 0 after reset; no starvation; one accept per idle cycle.
- Error paths, part 1: req0 target 14 -> accepted; err=1, done_id=0 next cycle; count unchanged.
- Error paths, part 2: reset pulse during a walk -> outputs go to reset values immediately; no done pulse.
- Error paths, part 3: force count off-path during a walk -> err after 7 steps.
